wb_timer_irq: RTL and testbench
===============================

Name: wb_timer_irq

Overview:
- Wishbone classic slave providing a prescaled 32-bit up-counter with compare-match interrupt.
- Sits on the system Wishbone interconnect as a peripheral alongside RAM and LEDs.
- Its `irq_o` feeds one bit of the CPU's `irq_i` vector, making it the upstream source of the core's timer interrupt.

Parameters:
- PRESCALE_WIDTH, 16, width of the prescaler divider register and counter.
- PRESCALE_RESET, 0, reset value of the PRESCALE register. A tick occurs every PRESCALE+1 clocks.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only bits [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane selects.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- irq_o  out  1  level interrupt to CPU.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values: all registers 0 except PRESCALE=PRESCALE_RESET. wb_ack_o=0, wb_dat_o=0, irq_o=0.
- Register map (adr[4:2]):
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; rest read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 2 COMPARE: 32 bits.
  - 3 COUNT: 32 bits, read/write.
  - 4 STATUS: bit0 PENDING; write-1-to-clear.
  - 5..7: read 0, writes ignored.
- Byte lane writes: a write updates only the bytes with wb_sel_i set. STATUS clear uses byte 0 only.
- Handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o asserts the cycle after a request and lasts exactly 1 cycle.
  - Write side effects take effect on the same edge ack is registered.
  - wb_dat_o is registered with ack and is 0 when ack is low.
  - Fixed latency 1 cycle per access; back-to-back accesses ack every 2nd cycle.
  - err/rty are not generated.
- Prescaler:
  - presc_cnt counts 0..PRESCALE while EN=1.
  - tick is a 1-cycle pulse when presc_cnt==PRESCALE, then presc_cnt wraps to 0.
  - EN=0 or any PRESCALE write clears presc_cnt to 0.
- Counter, on tick:
  - If COUNT==COMPARE: set PENDING. Then if AUTO_RELOAD, COUNT<=0; else COUNT<=COUNT+1 and EN<=0 (one-shot stop).
  - Otherwise COUNT<=COUNT+1, wrapping 0xFFFFFFFF->0 with no flag.
- Simultaneous events:
  - Bus write to COUNT and tick on the same edge: bus write wins, and the match check on that edge is suppressed.
  - Bus write to CTRL and one-shot EN clear on the same edge: bus write wins.
  - STATUS W1C and a new match on the same edge: set wins, PENDING stays 1.
- irq_o = PENDING & IRQ_EN. It is a level output from registers with no combinational bus path, and stays high until software clears PENDING or IRQ_EN.
- Reset asserted mid-access: ack drops next edge, the access is lost, and all state returns to reset values.

Decomposition:
- Shared package `wb_timer_pkg`:
  - register offset constants: REG_CTRL=0, REG_PRESCALE=1, REG_COMPARE=2, REG_COUNT=3, REG_STATUS=4;
  - CTRL bit indices: EN=0, AUTO_RELOAD=1, IRQ_EN=2.
- One natural sub-module, `timer_prescaler`: takes enable, divider value and clear; outputs the tick pulse.
- Register file, Wishbone decode and counter stay in the top module.

Test Plan:
- Reset then read all 8 offsets:
  - CTRL/COMPARE/COUNT/STATUS read 0, PRESCALE reads PRESCALE_RESET, offsets 5..7 read 0.
  - Every ack is exactly 1 cycle wide.
- PRESCALE=3, COMPARE=5, CTRL=0b111:
  - COUNT increments every 4 clocks.
  - PENDING and irq_o rise on the tick where COUNT==5, COUNT returns to 0, irq_o holds high.
  - Writing STATUS=1 drops irq_o the cycle after ack.
- One-shot: PRESCALE=0, COMPARE=2, CTRL=0b101:
  - match after 3 ticks, COUNT=3, EN reads 0, COUNT then stays 3.
- Byte lanes: write COMPARE=0xAABBCCDD with sel=0b0101 over 0 -> read back 0x00BB00DD.
- Collision cases:
  - W1C on the exact cycle of a new match leaves PENDING=1.
  - COUNT write on a tick edge loads the written value, with no increment and no match.
- Wrap: COUNT=0xFFFFFFFE, COMPARE=0x10, EN=1, PRESCALE=0:
  - COUNT reads 0 after 2 ticks, PENDING stays 0.
  - Assert rst_i during a pending read: ack drops next cycle, all registers return to reset values.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared register offsets, CTRL bit positions and byte-lane helper for the
// Wishbone prescaled timer.
package wb_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] result;
        result = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_timer_irq_prescaler.sv
// Clock divider: emits a one-cycle tick every divider+1 enabled clocks.
module timer_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] divider,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = en && (cnt == divider);

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer_irq.sv
// Wishbone classic timer peripheral: prescaled 32-bit up-counter with
// compare-match pending flag and level interrupt.
module wb_timer_irq
    import wb_timer_pkg::*;
#(
    parameter int unsigned                PRESCALE_WIDTH = 16,
    parameter logic [PRESCALE_WIDTH-1:0]  PRESCALE_RESET = '0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    logic [2:0]                ctrl;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [31:0]               compare;
    logic [31:0]               count;
    logic                      pending;

    logic [2:0]  reg_idx;
    logic        req;
    logic        wr;
    logic        prescale_wr;
    logic        count_wr;
    logic        status_clr;
    logic        tick;
    logic        match;
    logic [31:0] rdata;
    logic        unused_adr;

    assign reg_idx     = wb_adr_i[4:2];
    assign unused_adr  = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign req         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr          = req & wb_we_i;
    assign prescale_wr = wr && (reg_idx == REG_PRESCALE);
    assign count_wr    = wr && (reg_idx == REG_COUNT);
    assign status_clr  = wr && (reg_idx == REG_STATUS) && wb_sel_i[0] && wb_dat_i[0];
    // A bus write to COUNT on a tick edge also masks that edge's compare.
    assign match       = tick && !count_wr && (count == compare);
    assign irq_o       = pending & ctrl[CTRL_IRQ_EN];

    timer_prescaler #(
        .WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk_i),
        .rst     (rst_i),
        .en      (ctrl[CTRL_EN]),
        .clr     (prescale_wr),
        .divider (prescale),
        .tick    (tick)
    );

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:     rdata = {29'd0, ctrl};
            REG_PRESCALE: rdata = 32'(prescale);
            REG_COMPARE:  rdata = compare;
            REG_COUNT:    rdata = count;
            REG_STATUS:   rdata = {31'd0, pending};
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl     <= '0;
            prescale <= PRESCALE_RESET;
            compare  <= '0;
            count    <= '0;
            pending  <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : '0;

            // Assignment order encodes priority: match set beats W1C,
            // bus writes to CTRL/COUNT beat the counter's own updates.
            if (status_clr) pending <= 1'b0;
            if (match)      pending <= 1'b1;

            if (tick && !count_wr) begin
                if (match && ctrl[CTRL_AUTO_RELOAD]) begin
                    count <= '0;
                end else begin
                    count <= count + 32'd1;
                    if (match) ctrl[CTRL_EN] <= 1'b0;
                end
            end

            if (wr) begin
                case (reg_idx)
                    REG_CTRL: begin
                        if (wb_sel_i[0]) ctrl <= wb_dat_i[2:0];
                    end
                    REG_PRESCALE: begin
                        for (int unsigned i = 0; i < PRESCALE_WIDTH; i++) begin
                            if (wb_sel_i[i/8]) prescale[i] <= wb_dat_i[i];
                        end
                    end
                    REG_COMPARE: compare <= merge_bytes(compare, wb_dat_i, wb_sel_i);
                    REG_COUNT:   count   <= merge_bytes(count, wb_dat_i, wb_sel_i);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_timer_irq.sv
// Directed self-checking bench for wb_timer_irq with hand-computed timing.
module tb_wb_timer_irq;
    import wb_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_wdat;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [15:0] PRESC_RST = 16'd7;

    wb_timer_irq #(
        .PRESCALE_WIDTH (16),
        .PRESCALE_RESET (PRESC_RST)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_wdat),
        .wb_sel_i (wb_sel),
        .wb_dat_o (wb_rdat),
        .wb_ack_o (wb_ack),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; request sampled on the next edge, then one idle
    // cycle, so every access spans exactly two clock edges.
    task automatic wb_access(input logic we, input logic [2:0] idx, input logic [31:0] data,
                             input logic [3:0] sel, output logic [31:0] rd);
        int unsigned waited;
        waited  = 0;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = we;
        wb_adr  = {27'd0, idx, 2'b00};
        wb_wdat = data;
        wb_sel  = sel;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!wb_ack && waited < 4);
        check_eq("ack_latency", waited, 32'd1);
        rd     = wb_rdat;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ack_width", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(1'b1, idx, data, sel, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] got;
        wb_access(1'b0, idx, 32'd0, 4'hF, got);
        check_eq(tag, got, exp);
    endtask

    initial begin
        rst     = 1'b1;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        wb_we   = 1'b0;
        wb_adr  = '0;
        wb_wdat = '0;
        wb_sel  = '0;
        wait_cycles(3);
        rst = 1'b0;
        check_eq("rst_ack", {31'd0, wb_ack}, 32'd0);
        check_eq("rst_dat", wb_rdat, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            rd_chk("rst_read", 3'(i), (i == 1) ? 32'(PRESC_RST) : 32'd0);
        end

        // Periodic auto-reload: PRESCALE=3 so COUNT steps every 4 clocks.
        wr(REG_PRESCALE, 32'd3, 4'hF);
        wr(REG_COMPARE, 32'd5, 4'hF);
        wr(REG_CTRL, 32'd7, 4'hF);
        rd_chk("per_cnt0", REG_COUNT, 32'd0);
        wait_cycles(2);
        rd_chk("per_cnt1", REG_COUNT, 32'd1);
        wait_cycles(2);
        rd_chk("per_cnt2", REG_COUNT, 32'd2);
        rd_chk("per_stat0", REG_STATUS, 32'd0);
        check_eq("per_irq_lo", {31'd0, irq}, 32'd0);
        wait_cycles(10);
        check_eq("per_irq_pre", {31'd0, irq}, 32'd0);
        wait_cycles(1);
        check_eq("per_irq_rise", {31'd0, irq}, 32'd1);
        rd_chk("per_reload", REG_COUNT, 32'd0);
        rd_chk("per_pend", REG_STATUS, 32'd1);
        wait_cycles(8);
        check_eq("per_irq_hold", {31'd0, irq}, 32'd1);
        wr(REG_STATUS, 32'd1, 4'b0001);
        check_eq("per_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("per_stat_clr", REG_STATUS, 32'd0);
        wr(REG_CTRL, 32'd0, 4'hF);

        // One-shot: match on third tick, COUNT lands on 3 and EN self-clears.
        wr(REG_COUNT, 32'd0, 4'hF);
        wr(REG_PRESCALE, 32'd0, 4'hF);
        wr(REG_COMPARE, 32'd2, 4'hF);
        wr(REG_CTRL, 32'd5, 4'hF);
        wait_cycles(4);
        rd_chk("os_cnt", REG_COUNT, 32'd3);
        rd_chk("os_ctrl", REG_CTRL, 32'd4);
        check_eq("os_irq", {31'd0, irq}, 32'd1);
        wait_cycles(5);
        rd_chk("os_cnt_hold", REG_COUNT, 32'd3);
        wr(REG_STATUS, 32'd1, 4'b0001);
        wr(REG_CTRL, 32'd0, 4'hF);

        // Byte-lane write.
        wr(REG_COMPARE, 32'd0, 4'hF);
        wr(REG_COMPARE, 32'hAABBCCDD, 4'b0101);
        rd_chk("lane_cmp", REG_COMPARE, 32'h00BB00DD);

        // W1C lands on the same edge as a fresh match: PENDING must stay set.
        wr(REG_COUNT, 32'd0, 4'hF);
        wr(REG_COMPARE, 32'd2, 4'hF);
        wr(REG_CTRL, 32'd3, 4'hF);
        wait_cycles(1);
        wr(REG_STATUS, 32'd1, 4'b0001);
        rd_chk("col_w1c", REG_STATUS, 32'd1);
        wr(REG_CTRL, 32'd0, 4'hF);
        wr(REG_STATUS, 32'd1, 4'b0001);
        rd_chk("col_w1c_idle", REG_STATUS, 32'd0);

        // COUNT write on a tick edge that would otherwise match.
        wr(REG_PRESCALE, 32'd3, 4'hF);
        wr(REG_COMPARE, 32'd5, 4'hF);
        wr(REG_COUNT, 32'd5, 4'hF);
        wr(REG_CTRL, 32'd1, 4'hF);
        wait_cycles(2);
        wr(REG_COUNT, 32'h40, 4'hF);
        rd_chk("colcnt_val", REG_COUNT, 32'h40);
        rd_chk("colcnt_stat", REG_STATUS, 32'd0);
        rd_chk("colcnt_ctrl", REG_CTRL, 32'd1);
        rd_chk("colcnt_next", REG_COUNT, 32'h41);
        wr(REG_CTRL, 32'd0, 4'hF);

        // Wrap 0xFFFFFFFF -> 0 with no flag.
        wr(REG_PRESCALE, 32'd0, 4'hF);
        wr(REG_COMPARE, 32'h10, 4'hF);
        wr(REG_COUNT, 32'hFFFF_FFFE, 4'hF);
        wr(REG_CTRL, 32'd1, 4'hF);
        wait_cycles(1);
        rd_chk("wrap_cnt", REG_COUNT, 32'd0);
        rd_chk("wrap_stat", REG_STATUS, 32'd0);
        wr(REG_CTRL, 32'd0, 4'hF);

        // Reset during an outstanding read.
        wr(REG_COMPARE, 32'h1234, 4'hF);
        wr(REG_PRESCALE, 32'd9, 4'hF);
        wr(REG_CTRL, 32'd7, 4'hF);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b0;
        wb_adr = {27'd0, REG_COMPARE, 2'b00};
        rst    = 1'b1;
        wait_cycles(1);
        check_eq("rstacc_ack", {31'd0, wb_ack}, 32'd0);
        check_eq("rstacc_dat", wb_rdat, 32'd0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wait_cycles(1);
        rst = 1'b0;
        rd_chk("rstacc_ctrl", REG_CTRL, 32'd0);
        rd_chk("rstacc_presc", REG_PRESCALE, 32'(PRESC_RST));
        rd_chk("rstacc_cmp", REG_COMPARE, 32'd0);
        rd_chk("rstacc_cnt", REG_COUNT, 32'd0);
        rd_chk("rstacc_stat", REG_STATUS, 32'd0);
        check_eq("rstacc_irq", {31'd0, irq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
